// File: rtl/avalon_wrapper_core_if_pkg.sv
// Shared register map, control bit positions and width helpers
// for the Avalon-MM matrix multiplier wrapper.
package avalon_wrapper_core_if_pkg;

    localparam int REG_CONTROL = 0;
    localparam int REG_STATUS  = 1;
    localparam int REG_C_ADDR  = 2;
    localparam int REG_C_DATA  = 3;
    localparam int REG_A_ADDR  = 4;
    localparam int REG_A_DATA  = 5;
    localparam int REG_B_ADDR  = 6;
    localparam int REG_B_DATA  = 7;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int ADDR_W = 16;

    typedef enum logic [0:0] {
        S_IDLE,
        S_RUN
    } core_state_t;

    function automatic int c_width(input int dw, input int k);
        return 2 * dw + ((k > 1) ? $clog2(k) : 1) + 1;
    endfunction

    function automatic int data_in_width(input int nb, input int dw);
        return nb * dw;
    endfunction

    function automatic logic [15:0] merge16(
        input logic [15:0] old,
        input logic [15:0] wd,
        input logic [1:0]  be
    );
        logic [15:0] m;
        m[7:0]  = be[0] ? wd[7:0]  : old[7:0];
        m[15:8] = be[1] ? wd[15:8] : old[15:8];
        return m;
    endfunction

endpackage

// File: rtl/avalon_wrapper_core_if_if.sv
// Avalon-MM slave bus bundle with master and slave views.
interface avalon_wrapper_core_if_if
    import avalon_wrapper_core_if_pkg::*;
#(
    parameter int ID_WIDTH = 3,
    parameter int DIN_W    = data_in_width(4, 16),
    parameter int C_W      = c_width(16, 4)
);
    logic [ID_WIDTH-1:0] address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DIN_W-1:0]    writedata;
    logic [DIN_W/8-1:0]  byteenable;
    logic [C_W-1:0]      readdata;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_wrapper_core_if_core.sv
// Matrix multiplier core: word-loaded A/B stores, a PE_ROWS x PE_COLS
// MAC array tiled over C, and a synchronous C read port.
module matrix_multiplier_top
    import avalon_wrapper_core_if_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int N_BANKS    = 4,
    parameter int PE_ROWS    = M,
    parameter int PE_COLS    = N,
    parameter int ID_WIDTH   = 3
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         start,
    output logic                                         mult_done,
    input  logic                                         a_wr_en,
    input  logic [ADDR_W-1:0]                            a_wr_addr,
    input  logic [data_in_width(N_BANKS, DATA_WIDTH)-1:0] a_wr_data,
    input  logic                                         b_wr_en,
    input  logic [ADDR_W-1:0]                            b_wr_addr,
    input  logic [data_in_width(N_BANKS, DATA_WIDTH)-1:0] b_wr_data,
    input  logic [ADDR_W-1:0]                            c_rd_addr,
    output logic [c_width(DATA_WIDTH, K)-1:0]            c_rd_data
);
    localparam int CW   = c_width(DATA_WIDTH, K);
    localparam int A_SZ = M * K;
    localparam int B_SZ = K * N;
    localparam int C_SZ = M * N;
    localparam int AIW  = (A_SZ > 1) ? $clog2(A_SZ) : 1;
    localparam int BIW  = (B_SZ > 1) ? $clog2(B_SZ) : 1;
    localparam int CIW  = (C_SZ > 1) ? $clog2(C_SZ) : 1;
    localparam int TR   = (M + PE_ROWS - 1) / PE_ROWS;
    localparam int TC   = (N + PE_COLS - 1) / PE_COLS;

    if (ID_WIDTH < 3) begin : g_id_check
        $error("ID_WIDTH cannot decode the eight-register map");
    end

    logic [DATA_WIDTH-1:0] a_mem [A_SZ];
    logic [DATA_WIDTH-1:0] b_mem [B_SZ];
    logic [CW-1:0]         c_mem [C_SZ];

    core_state_t state;
    int          kk;
    int          tr;
    int          tc;

    logic           pe_ok   [PE_ROWS][PE_COLS];
    logic [CIW-1:0] pe_idx  [PE_ROWS][PE_COLS];
    logic [CW-1:0]  pe_prod [PE_ROWS][PE_COLS];

    // Operands are signed; sign-extend before multiplying.
    function automatic logic [CW-1:0] mul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [CW-1:0] ea;
        logic signed [CW-1:0] eb;
        ea = CW'($signed(a));
        eb = CW'($signed(b));
        return ea * eb;
    endfunction

    always_comb begin
        for (int r = 0; r < PE_ROWS; r++) begin
            for (int c = 0; c < PE_COLS; c++) begin
                pe_ok[r][c]   = (tr * PE_ROWS + r < M) && (tc * PE_COLS + c < N);
                pe_idx[r][c]  = '0;
                pe_prod[r][c] = '0;
                if (pe_ok[r][c]) begin
                    pe_idx[r][c]  = CIW'((tr * PE_ROWS + r) * N + tc * PE_COLS + c);
                    pe_prod[r][c] = mul(a_mem[AIW'((tr * PE_ROWS + r) * K + kk)],
                                        b_mem[BIW'(kk * N + tc * PE_COLS + c)]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            kk        <= 0;
            tr        <= 0;
            tc        <= 0;
            mult_done <= 1'b0;
            c_rd_data <= '0;
            for (int i = 0; i < A_SZ; i++) a_mem[i] <= '0;
            for (int i = 0; i < B_SZ; i++) b_mem[i] <= '0;
            for (int i = 0; i < C_SZ; i++) c_mem[i] <= '0;
        end else begin
            for (int j = 0; j < N_BANKS; j++) begin
                if (a_wr_en && int'(a_wr_addr) * N_BANKS + j < A_SZ)
                    a_mem[AIW'(int'(a_wr_addr) * N_BANKS + j)] <=
                        a_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                if (b_wr_en && int'(b_wr_addr) * N_BANKS + j < B_SZ)
                    b_mem[BIW'(int'(b_wr_addr) * N_BANKS + j)] <=
                        b_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
            c_rd_data <= (int'(c_rd_addr) < C_SZ) ? c_mem[CIW'(c_rd_addr)] : '0;
            // A start during a run simply restarts from the first tile.
            if (start) begin
                state     <= S_RUN;
                kk        <= 0;
                tr        <= 0;
                tc        <= 0;
                mult_done <= 1'b0;
            end else if (state == S_RUN) begin
                for (int r = 0; r < PE_ROWS; r++)
                    for (int c = 0; c < PE_COLS; c++)
                        if (pe_ok[r][c])
                            c_mem[pe_idx[r][c]] <= (kk == 0) ? pe_prod[r][c]
                                : c_mem[pe_idx[r][c]] + pe_prod[r][c];
                if (kk == K - 1) begin
                    kk <= 0;
                    if (tc == TC - 1) begin
                        tc <= 0;
                        if (tr == TR - 1) begin
                            tr        <= 0;
                            state     <= S_IDLE;
                            mult_done <= 1'b1;
                        end else begin
                            tr <= tr + 1;
                        end
                    end else begin
                        tc <= tc + 1;
                    end
                end else begin
                    kk <= kk + 1;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_wrapper_core_if.sv
// Avalon-MM register front end for the matrix multiplier core:
// address/holding registers, start/done control and the read mux.
module avalon_wrapper_core_if
    import avalon_wrapper_core_if_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int N_BANKS    = 4,
    parameter int PE_ROWS    = M,
    parameter int PE_COLS    = N,
    parameter int ID_WIDTH   = 3
) (
    input logic                    clk,
    input logic                    reset_n,
    avalon_wrapper_core_if_if.slave bus
);
    localparam int DIN_W = data_in_width(N_BANKS, DATA_WIDTH);
    localparam int CW    = c_width(DATA_WIDTH, K);
    localparam int BE_W  = DIN_W / 8;

    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] c_addr;
    logic [ADDR_W-1:0] a_wr_addr;
    logic [ADDR_W-1:0] b_wr_addr;
    logic [DIN_W-1:0]  a_hold;
    logic [DIN_W-1:0]  b_hold;
    logic              a_wr_en;
    logic              b_wr_en;
    logic              start;
    logic              done;
    logic              mult_done;
    logic              mult_done_q;
    logic [CW-1:0]     c_rd_data;

    assign wr = bus.chipselect & bus.write;
    assign rd = bus.chipselect & bus.read;
    assign bus.waitrequest = 1'b0;

    function automatic logic [DIN_W-1:0] merge_word(
        input logic [DIN_W-1:0] old,
        input logic [DIN_W-1:0] wd,
        input logic [BE_W-1:0]  be
    );
        logic [DIN_W-1:0] m;
        for (int i = 0; i < BE_W; i++)
            m[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_addr      <= '0;
            b_addr      <= '0;
            c_addr      <= '0;
            a_wr_addr   <= '0;
            b_wr_addr   <= '0;
            a_hold      <= '0;
            b_hold      <= '0;
            a_wr_en     <= 1'b0;
            b_wr_en     <= 1'b0;
            start       <= 1'b0;
            done        <= 1'b0;
            mult_done_q <= 1'b0;
        end else begin
            start       <= 1'b0;
            a_wr_en     <= 1'b0;
            b_wr_en     <= 1'b0;
            mult_done_q <= mult_done;
            if (mult_done && !mult_done_q)
                done <= 1'b1;
            // Clears below win over a same-cycle done edge.
            if (wr) begin
                case (bus.address)
                    ID_WIDTH'(REG_CONTROL): begin
                        start <= bus.writedata[CTRL_START];
                        if (bus.writedata[CTRL_START] || bus.writedata[CTRL_CLEAR])
                            done <= 1'b0;
                    end
                    ID_WIDTH'(REG_C_ADDR):
                        c_addr <= merge16(c_addr, bus.writedata[15:0], bus.byteenable[1:0]);
                    ID_WIDTH'(REG_A_ADDR):
                        a_addr <= merge16(a_addr, bus.writedata[15:0], bus.byteenable[1:0]);
                    ID_WIDTH'(REG_B_ADDR):
                        b_addr <= merge16(b_addr, bus.writedata[15:0], bus.byteenable[1:0]);
                    ID_WIDTH'(REG_A_DATA): begin
                        a_hold    <= merge_word(a_hold, bus.writedata, bus.byteenable);
                        a_wr_en   <= 1'b1;
                        a_wr_addr <= a_addr;
                        a_addr    <= a_addr + 1'b1;
                    end
                    ID_WIDTH'(REG_B_DATA): begin
                        b_hold    <= merge_word(b_hold, bus.writedata, bus.byteenable);
                        b_wr_en   <= 1'b1;
                        b_wr_addr <= b_addr;
                        b_addr    <= b_addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (rd) begin
            case (bus.address)
                ID_WIDTH'(REG_STATUS): bus.readdata = CW'(done);
                ID_WIDTH'(REG_C_ADDR): bus.readdata = CW'(c_addr);
                ID_WIDTH'(REG_C_DATA): bus.readdata = c_rd_data;
                ID_WIDTH'(REG_A_ADDR): bus.readdata = CW'(a_addr);
                ID_WIDTH'(REG_B_ADDR): bus.readdata = CW'(b_addr);
                default:               bus.readdata = '0;
            endcase
        end
    end

    matrix_multiplier_top #(
        .DATA_WIDTH (DATA_WIDTH),
        .M          (M),
        .K          (K),
        .N          (N),
        .N_BANKS    (N_BANKS),
        .PE_ROWS    (PE_ROWS),
        .PE_COLS    (PE_COLS),
        .ID_WIDTH   (ID_WIDTH)
    ) top_inst (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mult_done (mult_done),
        .a_wr_en   (a_wr_en),
        .a_wr_addr (a_wr_addr),
        .a_wr_data (a_hold),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .b_wr_data (b_hold),
        .c_rd_addr (c_addr),
        .c_rd_data (c_rd_data)
    );

endmodule

// File: tb/tb_avalon_wrapper_core_if.sv
// Directed bench for the Avalon matrix multiplier wrapper: register
// access, A/B loading, a full multiply and reset behaviour.
module tb_avalon_wrapper_core_if;
    import avalon_wrapper_core_if_pkg::*;

    localparam int CW = 35;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   start_cnt = 0;

    always #5 clk = ~clk;

    avalon_wrapper_core_if_if bus ();

    avalon_wrapper_core_if dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(negedge clk)
        if (dut.top_inst.start === 1'b1) start_cnt++;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [7:0] be);
        @(negedge clk);
        bus.address    = 3'(a);
        bus.writedata  = d;
        bus.byteenable = be;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        #1 check("waitrequest_wr", 64'(bus.waitrequest), 64'd0);
        @(posedge clk);
        #1 idle_bus();
    endtask

    task automatic rd(input int a, output logic [CW-1:0] d);
        @(negedge clk);
        bus.address    = 3'(a);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        #1;
        d = bus.readdata;
        check("waitrequest_rd", 64'(bus.waitrequest), 64'd0);
        @(posedge clk);
        #1 idle_bus();
    endtask

    task automatic rd_chk(input int a, input logic [63:0] exp, input string tag);
        logic [CW-1:0] v;
        rd(a, v);
        check(tag, 64'(v), exp);
    endtask

    task automatic poll_status(input int limit, output logic [CW-1:0] st);
        st = '0;
        for (int i = 0; i < limit && st[0] !== 1'b1; i++)
            rd(REG_STATUS, st);
    endtask

    initial begin
        logic [CW-1:0] st;
        logic [63:0]   w;

        idle_bus();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(dut.top_inst.start), 64'd0);
        check("rst_a_wr_en", 64'(dut.top_inst.a_wr_en), 64'd0);
        rd_chk(REG_STATUS, 64'd0, "rst_status");
        @(negedge clk) reset_n = 1'b1;

        rd_chk(REG_A_ADDR, 64'd0, "a_addr_after_reset");
        rd_chk(REG_C_ADDR, 64'd0, "c_addr_after_reset");

        wr(REG_CONTROL, 64'h3, 8'hFF);
        check("start_pulse", 64'(dut.top_inst.start), 64'd1);
        for (int i = 0; i < 100 && dut.top_inst.mult_done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("mult_done_rise", 64'(dut.top_inst.mult_done), 64'd1);
        poll_status(10, st);
        check("status_done", 64'(st), 64'd1);
        check("start_count_1", 64'(start_cnt), 64'd1);

        wr(REG_A_ADDR, 64'h1234, 8'hFF);
        wr(REG_A_DATA, 64'hABCD, 8'hFF);
        check("a_wr_en", 64'(dut.top_inst.a_wr_en), 64'd1);
        check("a_wr_addr", 64'(dut.top_inst.a_wr_addr), 64'h1234);
        check("a_wr_data", dut.top_inst.a_wr_data, 64'hABCD);
        rd_chk(REG_A_ADDR, 64'h1235, "a_addr_incr");
        check("a_wr_en_one_cycle", 64'(dut.top_inst.a_wr_en), 64'd0);

        wr(REG_A_DATA, 64'h11, 8'h01);
        check("a_wr_addr_2", 64'(dut.top_inst.a_wr_addr), 64'h1235);
        check("a_wr_data_merge", dut.top_inst.a_wr_data, 64'hAB11);

        rd_chk(REG_A_DATA, 64'd0, "a_data_read");
        rd_chk(REG_B_DATA, 64'd0, "b_data_read");
        rd_chk(REG_CONTROL, 64'd0, "control_read");

        wr(REG_A_ADDR, 64'hFFFF, 8'hFF);
        wr(REG_A_DATA, 64'h0, 8'hFF);
        check("a_wr_addr_ffff", 64'(dut.top_inst.a_wr_addr), 64'hFFFF);
        rd_chk(REG_A_ADDR, 64'd0, "a_addr_wrap");

        wr(REG_B_ADDR, 64'hBEEF, 8'h02);
        rd_chk(REG_B_ADDR, 64'hBE00, "b_addr_byte_lane");

        wr(REG_A_ADDR, 64'h0, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            w = 64'd1 << (16 * i);
            wr(REG_A_DATA, w, 8'hFF);
        end
        wr(REG_B_ADDR, 64'h0, 8'hFF);
        for (int r = 0; r < 4; r++) begin
            w = {16'(4*r+4), 16'(4*r+3), 16'(4*r+2), 16'(4*r+1)};
            wr(REG_B_DATA, w, 8'hFF);
        end
        rd_chk(REG_B_ADDR, 64'd4, "b_addr_after_load");

        wr(REG_CONTROL, 64'h1, 8'hFF);
        poll_status(50, st);
        check("status_after_mm", 64'(st), 64'd1);

        wr(REG_C_ADDR, 64'd0, 8'hFF);
        @(posedge clk);
        rd_chk(REG_C_DATA, 64'd1, "c_elem_0");
        wr(REG_C_ADDR, 64'd5, 8'hFF);
        @(posedge clk);
        rd_chk(REG_C_DATA, 64'd6, "c_elem_5");
        wr(REG_C_ADDR, 64'd15, 8'hFF);
        @(posedge clk);
        rd_chk(REG_C_DATA, 64'd16, "c_elem_15");
        rd_chk(REG_C_ADDR, 64'd15, "c_addr_read");

        wr(REG_CONTROL, 64'h2, 8'hFF);
        rd_chk(REG_STATUS, 64'd0, "status_cleared");
        check("start_count_2", 64'(start_cnt), 64'd2);

        wr(REG_CONTROL, 64'h1, 8'hFF);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_start", 64'(dut.top_inst.start), 64'd0);
        check("rst_mid_mult_done", 64'(dut.top_inst.mult_done), 64'd0);
        rd_chk(REG_STATUS, 64'd0, "rst_mid_status");
        @(negedge clk) reset_n = 1'b1;
        rd_chk(REG_STATUS, 64'd0, "post_rst_status");
        rd_chk(REG_A_ADDR, 64'd0, "post_rst_a_addr");
        rd_chk(REG_B_ADDR, 64'd0, "post_rst_b_addr");
        rd_chk(REG_C_ADDR, 64'd0, "post_rst_c_addr");
        check("start_count_3", 64'(start_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
